// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and defaults for the instruction fetch queue.
// Holds the fetch FSM state encoding and the default geometry and PC constants.
package instr_fetch_queue_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam int DEF_ADDR_W            = 32;
  localparam int DEF_INSTR_W           = 32;
  localparam int DEF_DEPTH             = 4;
  localparam int unsigned DEF_PC_INC   = 4;
  localparam int unsigned DEF_RESET_PC = 0;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Bundle of the instruction-memory request channel, redirect input and
// decode-facing queue head. The fetch queue uses the master modport.
interface instr_fetch_queue_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  // imem: imem_req/imem_addr held stable until the cycle imem_ack=1, which
  // completes the transfer. Decode: head transfers when instr_valid & instr_ready.
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               PCSrc;
  logic [ADDR_W-1:0]  branch_target;
  logic               instr_valid;
  logic [INSTR_W-1:0] Instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, Instr, instr_pc,
    input  imem_ack, imem_rdata, PCSrc, branch_target, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, Instr, instr_pc,
    output imem_ack, imem_rdata, PCSrc, branch_target, instr_ready
  );
endinterface

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// Small power-of-two FIFO of {pc, instr} entries with flush.
// Flush dominates push and pop; the head reads as zero while empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [W-1:0]     i_data,
  output logic [W-1:0]     o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push & ~i_flush;
  assign w_do_pop  = i_pop & ~i_flush & (r_count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the PC, issues one instruction-memory read at a time and
// queues returned words with their PCs for decode; redirects flush everything.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int          ADDR_W   = DEF_ADDR_W,
  parameter int          INSTR_W  = DEF_INSTR_W,
  parameter int          DEPTH    = DEF_DEPTH,
  parameter int unsigned PC_INC   = DEF_PC_INC,
  parameter int unsigned RESET_PC = DEF_RESET_PC
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_fetch_queue_if.master  bus,
  output fetch_state_t         o_dbg_state
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] INC    = ADDR_W'(PC_INC);

  fetch_state_t               r_state;
  logic [ADDR_W-1:0]          r_fetch_pc;
  logic [ADDR_W-1:0]          r_addr;
  logic                       r_req;

  logic                       w_push;
  logic                       w_pop;
  logic                       w_empty;
  logic [CNT_W-1:0]           w_count;
  logic [ADDR_W+INSTR_W-1:0]  w_head;

  // Only a completed, non-redirected request produces a queue entry.
  assign w_push = (r_state == REQ) & bus.imem_ack & ~bus.PCSrc;
  assign w_pop  = ~w_empty & bus.instr_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_fetch_pc <= RST_PC;
      r_addr     <= RST_PC;
      r_req      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.PCSrc) begin
            r_fetch_pc <= bus.branch_target;
          end else if (w_count < CNT_W'(DEPTH)) begin
            // Issuing only with a free slot guarantees the response fits.
            r_addr  <= r_fetch_pc;
            r_req   <= 1'b1;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (bus.PCSrc) begin
            r_fetch_pc <= bus.branch_target;
            if (bus.imem_ack) begin
              r_req   <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_state <= DISCARD;
            end
          end else if (bus.imem_ack) begin
            r_fetch_pc <= r_fetch_pc + INC;
            r_req      <= 1'b0;
            r_state    <= IDLE;
          end
        end
        DISCARD: begin
          if (bus.PCSrc) r_fetch_pc <= bus.branch_target;
          if (bus.imem_ack) begin
            r_req   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (ADDR_W + INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.PCSrc),
    .i_data  ({r_addr, bus.imem_rdata}),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_addr;
  assign bus.instr_valid = ~w_empty;
  assign bus.instr_pc    = w_head[ADDR_W+INSTR_W-1:INSTR_W];
  assign bus.Instr       = w_head[INSTR_W-1:0];
  assign o_dbg_state     = r_state;

endmodule
